// File: rtl/shift_add_multiplier.sv
// Unsigned WIDTHxWIDTH -> 2*WIDTH shift-and-add multiplier wrapped around an external ripple-carry adder.
// Latency: product valid exactly WIDTH cycles after the accepting edge, for any operand values.
// Backpressure: product held in DONE until out_ready; in_ready is high only in IDLE.
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_ci,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]  p_hi;
    logic [WIDTH-1:0]  p_lo;
    logic [CW-1:0]     cnt;

    // The adder sees the high half plus the multiplicand gated by the next multiplier bit.
    assign add_a   = p_hi;
    assign add_b   = p_lo[0] ? mcand_q : '0;
    assign add_ci  = 1'b0;
    assign product = {p_hi, p_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand_q   <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand_q  <= mcand;
                        p_hi     <= '0;
                        p_lo     <= mplier;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Carry-out becomes the top product bit as the running sum shifts right.
                    p_hi <= {add_co, add_sum[WIDTH-1:1]};
                    p_lo <= {add_sum[0], p_lo[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: models the attached adder, checks products against plain 64-bit multiply.
// Inputs change on the falling edge; outputs are sampled on or just after the falling edge.
// A free-running scoreboard checks every output handshake against the accepted operands.
module tb_shift_add_multiplier;

    localparam int W = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   product;
    logic             busy;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_ci;
    logic [W-1:0]     add_sum;
    logic             add_co;

    int vecs = 0;
    int errs = 0;

    logic [2*W-1:0] exp_q[$];
    int   cyc = 0;
    int   last_pop = 0;
    bit   have_last = 0;
    bit   b2b = 0;
    int   b2b_pops = 0;
    bit   co_seen = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_sum   (add_sum),
        .add_co    (add_co)
    );

    // Behavioural stand-in for the ripple-carry adder.
    assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vecs++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Scoreboard: queue of expected products, pushed on input handshake, popped on output handshake.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            have_last = 0;
        end else begin
            if (busy && !out_valid && add_co)
                co_seen = 1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    chk("sb_empty", 64'd1, 64'd0);
                else
                    chk("sb_product", product, exp_q.pop_front());
                if (b2b) begin
                    if (have_last)
                        chk("b2b_gap", 64'(cyc - last_pop), 64'd34);
                    b2b_pops++;
                end
                last_pop  = cyc;
                have_last = 1;
            end
            if (in_valid && in_ready)
                exp_q.push_back({32'd0, mcand} * {32'd0, mplier});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready)
            chk("idle_timeout", 64'(in_ready), 64'd1);
    endtask

    // One multiply: accept, measure latency, hold the result for 'stall' cycles, then hand it off.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        logic [63:0] want;
        int k;
        want = {32'd0, a} * {32'd0, b};
        wait_idle();
        in_valid = 1'b1;
        mcand    = a;
        mplier   = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        mcand    = $urandom;
        mplier   = $urandom;
        chk("run_busy", {62'd0, busy, in_ready}, 64'd2);
        k = 0;
        while (k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) break;
        end
        chk("latency", 64'(k), 64'd32);
        chk("product", product, want);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            mcand    = $urandom;
            mplier   = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk("hold_product", product, want);
            chk("hold_flags", {61'd0, out_valid, in_ready, busy}, 64'd5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("handoff_flags", {61'd0, out_valid, in_ready, busy}, 64'd2);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = '0;
        mplier    = '0;
        repeat (2) @(negedge clk);
        chk("reset_flags", {61'd0, out_valid, in_ready, busy}, 64'd2);
        chk("reset_product", product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_mul(32'd3, 32'd5, 0);
        chk("3x5", product, 64'h0000_0000_0000_000F);

        co_seen = 0;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("ffxff", product, 64'hFFFF_FFFE_0000_0001);
        chk("co_seen", 64'(co_seen), 64'd1);

        do_mul(32'd0, 32'h1234_5678, 0);
        do_mul(32'h1234_5678, 32'd0, 0);
        do_mul(32'h8000_0000, 32'd2, 10);
        chk("msb_x2", product, 64'h1 << 32);

        for (int i = 0; i < 12; i++)
            do_mul($urandom, $urandom, int'($urandom_range(0, 3)));
        do_mul(32'hFFFF_FFFF, $urandom, 1);
        do_mul($urandom, 32'h0000_0001, 0);

        // Back-to-back with in_valid held high and a consumer that is always ready.
        wait_idle();
        b2b       = 1;
        have_last = 0;
        b2b_pops  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 34 * 6; i++) begin
            mcand  = $urandom;
            mplier = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        b2b       = 0;
        out_ready = 1'b0;
        chk("b2b_count", 64'(b2b_pops >= 5), 64'd1);
        chk("b2b_drain", 64'(exp_q.size()), 64'd0);

        // Abort in the middle of a multiply.
        wait_idle();
        in_valid = 1'b1;
        mcand    = $urandom;
        mplier   = $urandom;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {61'd0, out_valid, in_ready, busy}, 64'd2);
        chk("abort_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_mul(32'd7, 32'd6, 0);
        chk("7x6", product, 64'd42);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
